mem_access_controller: RTL and testbench

//  MEM-stage sequencer between the pipeline and the data memory/cache (busywait handshake).

---
 rtl/mem_access_controller.sv | 161 ++++++++++++++++
 tb/tb_mem_access_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_controller.sv
// rtl/mem_access_controller.sv - MEM-stage load/store sequencer with busywait handshake and timeout
// One access at a time: IDLE captures the request, BUSY waits on memory, DONE reports the result.
module mem_access_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ_IN,
  input  logic        MEM_WRITE_IN,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        STALL,
  output logic [31:0] LOAD_DATA_OUT,
  output logic [2:0]  LOAD_SEL_OUT,
  output logic        DATA_VALID,
  output logic        ACCESS_ERR,
  output logic        DM_READ,
  output logic        DM_WRITE,
  output logic [31:0] DM_ADDR,
  output logic [31:0] DM_WDATA,
  output logic [3:0]  DM_BYTE_EN,
  input  logic [31:0] DM_RDATA,
  input  logic        DM_BUSYWAIT
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          is_load_q;

  logic        req_any, bad_f3, misaligned, req_bad, req_ok, timeout_hit;
  logic [31:0] shifted, aligned;

  always_comb begin
    req_any    = MEM_READ_IN | MEM_WRITE_IN;
    bad_f3     = MEM_READ_IN ? (FUNCT3 == 3'b011 || FUNCT3[2:1] == 2'b11) : (FUNCT3 >= 3'b011);
    misaligned = 1'b0;
    case (FUNCT3[1:0])
      2'b01:   misaligned = ADDR[0];
      2'b10:   misaligned = (ADDR[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    req_bad = req_any & ((MEM_READ_IN & MEM_WRITE_IN) | bad_f3 | misaligned);
    req_ok  = req_any & ~req_bad;
  end

  // counter holds completed busy cycles; abort on the edge that would make it TIMEOUT_CYCLES
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && DM_BUSYWAIT && ((int'(cnt) + 1) == TIMEOUT_CYCLES);

  always_comb begin
    shifted = DM_RDATA >> {off_q, 3'b000};
    case (f3_q[1:0])
      2'b00:   aligned = {shifted[7:0], 24'b0};
      2'b01:   aligned = {shifted[15:0], 16'b0};
      default: aligned = DM_RDATA;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    STALL      = 1'b0;
    case (state)
      IDLE: if (req_ok) begin
        STALL      = RESET;
        state_next = BUSY;
      end
      BUSY: begin
        STALL = 1'b1;
        if (!DM_BUSYWAIT || timeout_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      LOAD_DATA_OUT <= '0;
      LOAD_SEL_OUT  <= '0;
      DATA_VALID    <= 1'b0;
      ACCESS_ERR    <= 1'b0;
      DM_READ       <= 1'b0;
      DM_WRITE      <= 1'b0;
      DM_ADDR       <= '0;
      DM_WDATA      <= '0;
      DM_BYTE_EN    <= '0;
      cnt           <= '0;
      f3_q          <= '0;
      off_q         <= '0;
      is_load_q     <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      ACCESS_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (req_ok) begin
            DM_READ   <= MEM_READ_IN;
            DM_WRITE  <= MEM_WRITE_IN;
            DM_ADDR   <= {ADDR[31:2], 2'b00};
            f3_q      <= FUNCT3;
            off_q     <= ADDR[1:0];
            is_load_q <= MEM_READ_IN;
            cnt       <= '0;
            if (MEM_READ_IN) begin
              DM_WDATA   <= '0;
              DM_BYTE_EN <= 4'b1111;
            end else begin
              case (FUNCT3[1:0])
                2'b00: begin
                  DM_WDATA   <= {4{WDATA[7:0]}};
                  DM_BYTE_EN <= 4'b0001 << ADDR[1:0];
                end
                2'b01: begin
                  DM_WDATA   <= {2{WDATA[15:0]}};
                  DM_BYTE_EN <= ADDR[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                  DM_WDATA   <= WDATA;
                  DM_BYTE_EN <= 4'b1111;
                end
              endcase
            end
          end else if (req_bad) begin
            ACCESS_ERR <= 1'b1;
          end
        end
        BUSY: begin
          if (!DM_BUSYWAIT) begin
            DM_READ  <= 1'b0;
            DM_WRITE <= 1'b0;
            if (is_load_q) begin
              LOAD_DATA_OUT <= aligned;
              LOAD_SEL_OUT  <= f3_q;
              DATA_VALID    <= 1'b1;
            end
          end else if (timeout_hit) begin
            DM_READ       <= 1'b0;
            DM_WRITE      <= 1'b0;
            LOAD_DATA_OUT <= '0;
            ACCESS_ERR    <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// tb/tb_mem_access_controller.sv - directed bench with per-cycle transaction model for mem_access_controller
// Each access computes its expected cycle-by-cycle trace from the load/store rules; one process compares.
module tb_mem_access_controller;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        MEM_READ_IN = 1'b0, MEM_WRITE_IN = 1'b0;
  logic [2:0]  FUNCT3 = '0;
  logic [31:0] ADDR = '0, WDATA = '0, DM_RDATA = '0;
  logic        DM_BUSYWAIT = 1'b0;
  logic        STALL, DATA_VALID, ACCESS_ERR, DM_READ, DM_WRITE;
  logic [31:0] LOAD_DATA_OUT, DM_ADDR, DM_WDATA;
  logic [2:0]  LOAD_SEL_OUT;
  logic [3:0]  DM_BYTE_EN;

  mem_access_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ_IN(MEM_READ_IN), .MEM_WRITE_IN(MEM_WRITE_IN),
    .FUNCT3(FUNCT3), .ADDR(ADDR), .WDATA(WDATA), .STALL(STALL), .LOAD_DATA_OUT(LOAD_DATA_OUT),
    .LOAD_SEL_OUT(LOAD_SEL_OUT), .DATA_VALID(DATA_VALID), .ACCESS_ERR(ACCESS_ERR),
    .DM_READ(DM_READ), .DM_WRITE(DM_WRITE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
    .DM_BYTE_EN(DM_BYTE_EN), .DM_RDATA(DM_RDATA), .DM_BUSYWAIT(DM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int errors = 0, checks = 0;
  int stall_total = 0, dv_total = 0, err_total = 0, strobe_total = 0, wr_total = 0;
  logic [31:0] last_wd = '0;
  logic [3:0]  last_be = '0;

  logic        exp_on = 1'b1;
  logic        e_stall = 0, e_rd = 0, e_wr = 0, e_dv = 0, e_err = 0, e_chk_dm = 0;
  logic [31:0] e_addr = '0, e_wd = '0, m_ld = '0;
  logic [3:0]  e_be = '0;
  logic [2:0]  m_ls = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_invalid(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] addr);
    if (rd && wr) return 1'b1;
    if (!rd && !wr) return 1'b0;
    if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if (wr && f3 >= 3'd3) return 1'b1;
    if (f3[1:0] == 2'd1 && addr % 2 != 0) return 1'b1;
    if (f3[1:0] == 2'd2 && addr % 4 != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int o;
    o = int'(addr % 4);
    case (f3)
      3'b000, 3'b100: return ((rdata >> (8 * o)) & 32'hFF) << 24;
      3'b001, 3'b101: return ((rdata >> (8 * o)) & 32'hFFFF) << 16;
      default:        return rdata;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  return (wd & 32'hFF) * 32'h01010101;
      3'b001:  return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic rd, input logic [2:0] f3, input logic [31:0] addr);
    if (rd) return 4'b1111;
    case (f3)
      3'b000:  return 4'(1 << (addr % 4));
      3'b001:  return (addr % 4 == 2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  always @(negedge CLK) begin
    stall_total  += int'(STALL);
    dv_total     += int'(DATA_VALID);
    err_total    += int'(ACCESS_ERR);
    strobe_total += int'(DM_READ | DM_WRITE);
    if (DM_WRITE) begin
      wr_total++;
      last_wd = DM_WDATA;
      last_be = DM_BYTE_EN;
    end
    if (exp_on) begin
      chk("stall", 32'(STALL), 32'(e_stall));
      chk("dm_read", 32'(DM_READ), 32'(e_rd));
      chk("dm_write", 32'(DM_WRITE), 32'(e_wr));
      chk("data_valid", 32'(DATA_VALID), 32'(e_dv));
      chk("access_err", 32'(ACCESS_ERR), 32'(e_err));
      chk("load_data", LOAD_DATA_OUT, m_ld);
      chk("load_sel", 32'(LOAD_SEL_OUT), 32'(m_ls));
      if (e_chk_dm) begin
        chk("dm_addr", DM_ADDR, e_addr);
        chk("dm_be", 32'(DM_BYTE_EN), 32'(e_be));
        if (e_wr) chk("dm_wdata", DM_WDATA, e_wd);
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int nbusy);
    logic bad, to;
    int   nb;
    bad = m_invalid(rd, wr, f3, addr);
    to  = (TO != 0) && (nbusy >= TO);
    nb  = to ? TO : nbusy + 1;
    @(posedge CLK); #1;
    MEM_READ_IN = rd; MEM_WRITE_IN = wr; FUNCT3 = f3; ADDR = addr; WDATA = wd;
    DM_RDATA = rdata; DM_BUSYWAIT = 1'b0;
    e_stall = !bad; e_rd = 0; e_wr = 0; e_dv = 0; e_err = 0; e_chk_dm = 0;
    if (!bad) begin
      for (int k = 1; k <= nb; k++) begin
        @(posedge CLK); #1;
        DM_BUSYWAIT = (k <= nbusy);
        e_stall = 1; e_rd = rd; e_wr = wr; e_chk_dm = 1;
        e_addr = addr & ~32'h3; e_wd = m_wdata(f3, wd); e_be = m_be(rd, f3, addr);
      end
    end
    @(posedge CLK); #1;
    MEM_READ_IN = 0; MEM_WRITE_IN = 0; DM_BUSYWAIT = 0;
    e_stall = 0; e_rd = 0; e_wr = 0; e_chk_dm = 0;
    if (bad || to) begin
      e_err = 1;
      if (to) m_ld = '0;
    end else if (rd) begin
      e_dv = 1; m_ld = m_load(f3, addr, rdata); m_ls = f3;
    end
    @(posedge CLK); #1;
    e_dv = 0; e_err = 0;
  endtask

  initial begin
    int s0, d0, r0, st0, w0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_stall", 32'(STALL), 32'd0);
    chk("rst_ldata", LOAD_DATA_OUT, 32'd0);
    chk("rst_dm_addr", DM_ADDR, 32'd0);
    RESET = 1'b1;

    s0 = stall_total; d0 = dv_total;
    access(1, 0, 3'b000, 32'h1001, 0, 32'hABCD1234, 3);
    chk("t1_stall_cycles", 32'(stall_total - s0), 32'd5);
    chk("t1_ldata", LOAD_DATA_OUT, 32'h12000000);
    chk("t1_lsel", 32'(LOAD_SEL_OUT), 32'd0);
    chk("t1_dv_pulses", 32'(dv_total - d0), 32'd1);

    s0 = stall_total;
    access(1, 0, 3'b101, 32'h2002, 0, 32'hABCD1234, 0);
    chk("t2_stall_cycles", 32'(stall_total - s0), 32'd2);
    chk("t2_ldata", LOAD_DATA_OUT, 32'hABCD0000);
    chk("t2_lsel", 32'(LOAD_SEL_OUT), 32'd5);

    d0 = dv_total; w0 = wr_total;
    access(0, 1, 3'b000, 32'h3003, 32'h000000EE, 0, 1);
    chk("t3_wdata", last_wd, 32'hEEEEEEEE);
    chk("t3_be", 32'(last_be), 32'h8);
    chk("t3_dv_pulses", 32'(dv_total - d0), 32'd0);
    chk("t3_wr_seen", 32'(wr_total - w0 > 0), 32'd1);
    chk("t3_ldata_hold", LOAD_DATA_OUT, 32'hABCD0000);

    r0 = err_total; st0 = strobe_total; s0 = stall_total;
    access(1, 0, 3'b010, 32'h4002, 0, 0, 0);
    access(0, 1, 3'b001, 32'h4001, 32'h5555, 0, 0);
    access(1, 0, 3'b001, 32'h4003, 0, 0, 0);
    access(1, 0, 3'b110, 32'h4000, 0, 0, 0);
    access(0, 1, 3'b011, 32'h4000, 0, 0, 0);
    access(1, 1, 3'b010, 32'h4000, 0, 0, 0);
    chk("t4_err_pulses", 32'(err_total - r0), 32'd6);
    chk("t4_no_strobe", 32'(strobe_total - st0), 32'd0);
    chk("t4_no_stall", 32'(stall_total - s0), 32'd0);

    access(0, 1, 3'b001, 32'h5002, 32'h1234BEEF, 0, 1);
    chk("sh_hi_wdata", last_wd, 32'hBEEFBEEF);
    chk("sh_hi_be", 32'(last_be), 32'hC);
    access(0, 1, 3'b010, 32'h5004, 32'hCAFEF00D, 0, 2);
    access(1, 0, 3'b100, 32'h7003, 0, 32'h89ABCDEF, 1);
    chk("lbu_ldata", LOAD_DATA_OUT, 32'h89000000);
    access(1, 0, 3'b001, 32'h7000, 0, 32'h89ABCDEF, 2);
    chk("lh_ldata", LOAD_DATA_OUT, 32'hCDEF0000);
    access(1, 0, 3'b010, 32'h7004, 0, 32'h13579BDF, TO - 1);
    chk("lw_edge_ldata", LOAD_DATA_OUT, 32'h13579BDF);

    r0 = err_total; d0 = dv_total; s0 = stall_total;
    access(1, 0, 3'b010, 32'h8000, 0, 32'hFFFFFFFF, 40);
    chk("t5_err_pulses", 32'(err_total - r0), 32'd1);
    chk("t5_dv_pulses", 32'(dv_total - d0), 32'd0);
    chk("t5_ldata", LOAD_DATA_OUT, 32'd0);
    chk("t5_stall_cycles", 32'(stall_total - s0), 32'(TO + 1));

    exp_on = 0;
    @(posedge CLK); #1;
    MEM_READ_IN = 1; FUNCT3 = 3'b010; ADDR = 32'h6000; DM_RDATA = 32'h600D600D;
    @(posedge CLK); #1;
    DM_BUSYWAIT = 1;
    @(posedge CLK); #1;
    chk("t6_pre_read", 32'(DM_READ), 32'd1);
    d0 = dv_total; r0 = err_total;
    RESET = 0;
    #1;
    chk("t6_read_drop", 32'(DM_READ), 32'd0);
    chk("t6_stall_drop", 32'(STALL), 32'd0);
    chk("t6_addr_clr", DM_ADDR, 32'd0);
    @(posedge CLK); #1;
    MEM_READ_IN = 0; DM_BUSYWAIT = 0;
    @(posedge CLK); #1;
    RESET = 1;
    m_ld = '0; m_ls = '0;
    e_stall = 0; e_rd = 0; e_wr = 0; e_dv = 0; e_err = 0; e_chk_dm = 0;
    exp_on = 1;
    repeat (3) @(posedge CLK);
    #1;
    chk("t6_no_dv", 32'(dv_total - d0), 32'd0);
    chk("t6_no_err", 32'(err_total - r0), 32'd0);

    access(1, 0, 3'b000, 32'h9002, 0, 32'h00A50000, 1);
    chk("post_rst_ldata", LOAD_DATA_OUT, 32'hA5000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
